// File: rtl/fetch_ctrl_if.sv
// Handshake and control bundle between the IF-stage sequencer and its surroundings.
// master = the fetch controller, slave = PC/ROM datapath plus hazard/branch logic.
interface fetch_ctrl_if #(
   parameter int unsigned ARQ    = 16,
   parameter int unsigned ADDR_W = 6
);
   logic              start;
   logic [ADDR_W-1:0] start_addr;
   logic              stall;
   logic              br_req;
   logic [ADDR_W-1:0] br_target;
   logic [ARQ-1:0]    instr_in;

   logic              pc_en;
   logic              mux_sel;
   logic [ADDR_W-1:0] branch_addr;
   logic              ifid_en;
   logic              ifid_flush;
   logic              busy;
   logic              halted;
   logic              wdog_err;
   logic [15:0]       fetch_cnt;

   modport master (
      input  start, start_addr, stall, br_req, br_target, instr_in,
      output pc_en, mux_sel, branch_addr, ifid_en, ifid_flush,
             busy, halted, wdog_err, fetch_cnt
   );

   modport slave (
      output start, start_addr, stall, br_req, br_target, instr_in,
      input  pc_en, mux_sel, branch_addr, ifid_en, ifid_flush,
             busy, halted, wdog_err, fetch_cnt
   );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: start/restart, stalls, redirects, HALT drain.
// Optional stall watchdog enabled by defining FETCH_WATCHDOG_EN.
module fetch_ctrl #(
   parameter int unsigned ARQ          = 16,
   parameter int unsigned ADDR_W       = 6,
   parameter logic [3:0]  HALT_OPC     = 4'hF,
   parameter int unsigned DRAIN_CYCLES = 3
`ifdef FETCH_WATCHDOG_EN
   ,
   parameter int unsigned STALL_LIMIT  = 64
`endif
) (
   input  logic          clk,
   input  logic          rst,
   fetch_ctrl_if.master  bus
);

   localparam int unsigned OPC_W   = 4;
   localparam int unsigned DRAIN_W = 4;
   localparam int unsigned CNT_W   = 16;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   state_t               state, state_nxt;
   logic [DRAIN_W-1:0]   drain_cnt, drain_nxt;
   logic [CNT_W-1:0]     fetch_cnt_q;
   logic                 cnt_inc;

   logic                 pc_en_c;
   logic                 mux_sel_c;
   logic [ADDR_W-1:0]    branch_addr_c;
   logic                 ifid_en_c;
   logic                 ifid_flush_c;

   logic [OPC_W-1:0]     opcode;
   logic                 unused_instr_lo;

   assign opcode          = bus.instr_in[ARQ-1 -: OPC_W];
   assign unused_instr_lo = ^bus.instr_in[ARQ-OPC_W-1:0];

`ifdef FETCH_WATCHDOG_EN
   localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(STALL_LIMIT - 1);

   logic [CNT_W-1:0]     stall_cnt, stall_cnt_nxt;
   logic                 wdog_q;
   logic                 wdog_set;
`endif

   // State, drain counter and saturating fetch counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         drain_cnt   <= '0;
         fetch_cnt_q <= '0;
      end else begin
         state     <= state_nxt;
         drain_cnt <= drain_nxt;
         if (cnt_inc && (fetch_cnt_q != CNT_MAX)) begin
            fetch_cnt_q <= fetch_cnt_q + CNT_W'(1);
         end
      end
   end

`ifdef FETCH_WATCHDOG_EN
   // Consecutive-stall counter and sticky watchdog flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
         wdog_q    <= 1'b0;
      end else begin
         stall_cnt <= stall_cnt_nxt;
         if (wdog_set) begin
            wdog_q <= 1'b1;
         end
      end
   end
`endif

   // Next state and same-cycle PC / IF-ID controls
   always_comb begin
      state_nxt     = state;
      drain_nxt     = drain_cnt;
      cnt_inc       = 1'b0;
      pc_en_c       = 1'b0;
      mux_sel_c     = 1'b0;
      branch_addr_c = '0;
      ifid_en_c     = 1'b0;
      ifid_flush_c  = 1'b0;
`ifdef FETCH_WATCHDOG_EN
      stall_cnt_nxt = stall_cnt;
      wdog_set      = 1'b0;
`endif

      unique case (state)
         S_IDLE, S_HALT: begin
            ifid_flush_c = 1'b1;
            if (bus.start) begin
               pc_en_c       = 1'b1;
               mux_sel_c     = 1'b1;
               branch_addr_c = bus.start_addr;
               state_nxt     = S_RUN;
            end
         end

         S_RUN: begin
            if (bus.br_req) begin
               pc_en_c       = 1'b1;
               mux_sel_c     = 1'b1;
               branch_addr_c = bus.br_target;
               ifid_en_c     = 1'b1;
               ifid_flush_c  = 1'b1;
`ifdef FETCH_WATCHDOG_EN
               stall_cnt_nxt = '0;
`endif
            end else if (bus.stall) begin
`ifdef FETCH_WATCHDOG_EN
               if (stall_cnt == STALL_LAST) begin
                  wdog_set      = 1'b1;
                  stall_cnt_nxt = '0;
                  state_nxt     = S_HALT;
               end else begin
                  stall_cnt_nxt = stall_cnt + CNT_W'(1);
               end
`endif
            end else if (opcode == HALT_OPC) begin
               // HALT itself still enters IF/ID so it reaches decode
               ifid_en_c = 1'b1;
               cnt_inc   = 1'b1;
               drain_nxt = DRAIN_W'(DRAIN_CYCLES);
               state_nxt = S_DRAIN;
`ifdef FETCH_WATCHDOG_EN
               stall_cnt_nxt = '0;
`endif
            end else begin
               pc_en_c   = 1'b1;
               ifid_en_c = 1'b1;
               cnt_inc   = 1'b1;
`ifdef FETCH_WATCHDOG_EN
               stall_cnt_nxt = '0;
`endif
            end
         end

         S_DRAIN: begin
            ifid_en_c    = 1'b1;
            ifid_flush_c = 1'b1;
            if (bus.br_req) begin
               // An older branch resolved behind the HALT: resume fetching
               pc_en_c       = 1'b1;
               mux_sel_c     = 1'b1;
               branch_addr_c = bus.br_target;
               drain_nxt     = '0;
               state_nxt     = S_RUN;
            end else if (drain_cnt <= DRAIN_W'(1)) begin
               drain_nxt = '0;
               state_nxt = S_HALT;
            end else begin
               drain_nxt = drain_cnt - DRAIN_W'(1);
            end
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Controls read zero while reset is asserted
   assign bus.pc_en       = rst & pc_en_c;
   assign bus.mux_sel     = rst & mux_sel_c;
   assign bus.branch_addr = rst ? branch_addr_c : '0;
   assign bus.ifid_en     = rst & ifid_en_c;
   assign bus.ifid_flush  = rst & ifid_flush_c;
   assign bus.busy        = (state == S_RUN) || (state == S_DRAIN);
   assign bus.halted      = (state == S_HALT);
   assign bus.fetch_cnt   = fetch_cnt_q;

`ifdef FETCH_WATCHDOG_EN
   assign bus.wdog_err = wdog_q;
`else
   assign bus.wdog_err = 1'b0;
`endif

endmodule
